// File: rtl/uart_pkg.sv
// Shared UART TX definitions: FSM state encodings, parity types and line levels.
// No logic; referenced by the TX control FSM and its helpers.
// Line-level constants keep start/stop/idle polarity in one place.
package uart_pkg;

  // One-hot is not needed at this rate; a compact binary encoding leaves
  // three unused codes that the FSM steers back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity generator: reduction XOR of the data word, inverted for odd parity.
// Latency: combinational; the FSM registers the result at byte acceptance.
// No flow control; output simply follows the inputs.
module parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even; odd flips that bit.
  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART TX control FSM: sequences start, data (from serializer), optional parity, stop.
// Latency: start bit on the line the cycle after DATA_VALID is sampled in IDLE.
// Backpressure: bytes are taken only in IDLE (busy=0); DATA_VALID while busy is ignored.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  tx_state_t state;
  tx_state_t next_state;
  logic      par_bit;
  logic      par_bit_lat;
  logic      par_en_lat;
  logic      accept;

  // A byte is taken only while idle; the serializer loads at the same edge.
  assign accept = (state == ST_IDLE) && DATA_VALID;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit)
  );

  // State register; async reset drops the line back to idle immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Parity bit and parity enable are frozen at acceptance so mid-frame
  // changes on P_DATA/PAR_EN/PAR_TYP cannot disturb the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit_lat <= 1'b0;
      par_en_lat  <= 1'b0;
    end else if (accept) begin
      par_bit_lat <= par_bit;
      par_en_lat  <= PAR_EN;
    end
  end

  // Next-state and Moore outputs; TX_OUT stays combinational so data bits
  // line up with the serializer's registered ser_data.
  always_comb begin
    next_state = ST_IDLE;
    ser_en     = 1'b0;
    busy       = 1'b0;
    TX_OUT     = IDLE_LINE;
    case (state)
      ST_IDLE: begin
        next_state = accept ? ST_START : ST_IDLE;
      end
      ST_START: begin
        busy       = 1'b1;
        TX_OUT     = START_BIT;
        next_state = ST_DATA;
      end
      ST_DATA: begin
        busy   = 1'b1;
        ser_en = 1'b1;
        TX_OUT = ser_data;
        if (ser_done) begin
          next_state = par_en_lat ? ST_PARITY : ST_STOP;
        end else begin
          next_state = ST_DATA;
        end
      end
      ST_PARITY: begin
        busy       = 1'b1;
        TX_OUT     = par_bit_lat;
        next_state = ST_STOP;
      end
      ST_STOP: begin
        busy       = 1'b1;
        TX_OUT     = STOP_BIT;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule
